// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered status flags and an occupancy count.
// Build option SYNC_FIFO_STICKY_ERR_EN: overflow/underflow hold until rst instead of pulsing for one cycle.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
        end
        if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_evt;
    logic                  udf_evt;
    logic [CW-1:0]         count_nxt;

    // A read on a full FIFO frees a slot, so the concurrent write is taken.
    always_comb begin
        rd_acc    = rd_en & ~empty;
        wr_acc    = wr_en & (~full | rd_en);
        ovf_evt   = wr_en & full & ~rd_en;
        udf_evt   = rd_en & empty;
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are derived from count_nxt so they line up with count every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
`ifdef SYNC_FIFO_STICKY_ERR_EN
            overflow     <= overflow | ovf_evt;
            underflow    <= underflow | udf_evt;
`else
            overflow     <= ovf_evt;
            underflow    <= udf_evt;
`endif
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: self-checking bench for sync_fifo_param using a queue model of the FIFO contents.
// Sticky error checks are compiled in when SYNC_FIFO_STICKY_ERR_EN is defined.
module tb_sync_fifo_param;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AF  = 12;
    localparam int AE  = 4;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int            n_checks = 0;
    int            n_fail   = 0;

    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = sb_q.size();
        check({tag, ".count"}, 32'(count), n);
        check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check({tag, ".full"}, 32'(full), 32'(n == DEP));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // One clock of traffic: predict from the queue, clock the DUT, compare 1 time unit later.
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
        logic f_m, e_m, ovf_e, udf_e;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        f_m   = (sb_q.size() == DEP);
        e_m   = (sb_q.size() == 0);
        ovf_e = w && f_m && !r;
        udf_e = r && e_m;
        if (r && !e_m) m_dout = sb_q.pop_front();
        if (w && (!f_m || r)) sb_q.push_back(d);
`ifdef SYNC_FIFO_STICKY_ERR_EN
        m_ovf = m_ovf | ovf_e;
        m_udf = m_udf | udf_e;
`else
        m_ovf = ovf_e;
        m_udf = udf_e;
`endif
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        cycle("idle", 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < DEP; i++) cycle("fill", 1'b1, DW'(i), 1'b0);
        check("fill.full_const", 32'(full), 32'd1);
        check("fill.count_const", 32'(count), 32'd16);

        cycle("ovf", 1'b1, 8'hEE, 1'b0);
        check("ovf.pulse", 32'(overflow), 32'd1);
        cycle("ovf_after", 1'b0, 8'h00, 1'b0);

        cycle("full_wr_rd", 1'b1, 8'hAA, 1'b1);
        check("full_wr_rd.dout", 32'(data_out), 32'h00);
        check("full_wr_rd.count", 32'(count), 32'd16);

        for (int i = 0; i < DEP; i++) cycle("drain", 1'b0, 8'h00, 1'b1);
        check("drain.last_aa", 32'(data_out), 32'hAA);

        cycle("udf", 1'b0, 8'h00, 1'b1);
        check("udf.dout_hold", 32'(data_out), 32'hAA);
        cycle("empty_wr_rd", 1'b1, 8'h55, 1'b1);
        check("empty_wr_rd.count", 32'(count), 32'd1);
        cycle("read_55", 1'b0, 8'h00, 1'b1);
        check("read_55.dout", 32'(data_out), 32'h55);

        for (int i = 0; i < 40; i++) begin
            cycle("wrap", 1'b1, DW'(8'h80 + i), ((i % 4) != 0));
            if (count > CW'(DEP)) check("wrap.count_range", 32'(count), 32'(DEP));
        end
        while (sb_q.size() != 0) cycle("wrap_drain", 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 10; i++) cycle("burst", 1'b1, DW'(8'hC0 + i), (i == 5));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #3;
        rst = 1'b0;
        cycle("post_rst", 1'b0, 8'h00, 1'b0);

`ifdef SYNC_FIFO_STICKY_ERR_EN
        for (int i = 0; i < DEP; i++) cycle("sticky_fill", 1'b1, DW'(i), 1'b0);
        cycle("sticky_ovf", 1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) cycle("sticky_hold", 1'b0, 8'h00, 1'b0);
        check("sticky.ovf_held", 32'(overflow), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("sticky_rst");
        rst = 1'b0;
        cycle("sticky_post", 1'b0, 8'h00, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
